// File: rtl/dec3_8_pkg.sv
`timescale 1ns / 1ps
// Shared constants for the gate-level register-file decoders.
package dec3_8_pkg;

  localparam int  DEC_SEL_W  = 3;
  localparam int  DEC_OUT_W  = 8;

  // Default primitive delay used throughout the gate-level register file.
  localparam real GATE_DELAY = 0.05;

  // True when index idx uses the uncomplemented literal of select bit pos.
  function automatic bit selBit(input int idx, input int pos);
    return ((idx >> pos) & 1) != 0;
  endfunction

endpackage

// File: rtl/dec3_8_and4.sv
`timescale 1ns / 1ps
// 4-input AND primitive wrapper; the delay models the gate in simulation only.
module dec_and4 #(
  parameter real DELAY = 0.05
) (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  and #(DELAY) u_gate (y, a, b, c, d);

endmodule

// File: rtl/dec3_8.sv
`timescale 1ns / 1ps
// 3-to-8 one-hot decoder with active-high enable. Leaf cell of the
// register-file write-select tree. Gate-level decode, optional output flops.
module dec3_8
  import dec3_8_pkg::*;
#(
  parameter int  REGISTERED = 0,
  parameter real DELAY      = GATE_DELAY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DEC_SEL_W-1:0] WriteRegister,
  input  logic                 RegWrite,
  output logic [DEC_OUT_W-1:0] en
);

  logic [DEC_SEL_W-1:0] selN;
  logic [DEC_OUT_W-1:0] decoded;

  // Complemented select literals, one inverter per bit.
  for (genvar k = 0; k < DEC_SEL_W; k++) begin : g_inv
    not #(DELAY) u_inv (selN[k], WriteRegister[k]);
  end

  // One AND4 per output: RegWrite plus the true/complement literal of each
  // select bit chosen from the binary pattern of the output index.
  for (genvar i = 0; i < DEC_OUT_W; i++) begin : g_dec
    logic [DEC_SEL_W-1:0] lit;

    for (genvar k = 0; k < DEC_SEL_W; k++) begin : g_lit
      if (selBit(i, k)) begin : g_true
        assign lit[k] = WriteRegister[k];
      end else begin : g_comp
        assign lit[k] = selN[k];
      end
    end

    dec_and4 #(.DELAY(DELAY)) u_and (
      .a (RegWrite),
      .b (lit[2]),
      .c (lit[1]),
      .d (lit[0]),
      .y (decoded[i])
    );
  end

  if (REGISTERED != 0) begin : g_reg
    logic [DEC_OUT_W-1:0] enQ;

    // Capture the decode each rising edge; reset clears without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        enQ <= '0;
      end else begin
        enQ <= decoded;
      end
    end

    assign en = enQ;
  end else begin : g_comb
    // Clock and reset are unused in the combinational build.
    logic unusedCtl;
    assign unusedCtl = &{1'b0, clk, rst_n};

    assign en = decoded;
  end

endmodule

// File: tb/tb_dec3_8.sv
`timescale 1ns / 1ps
// Self-checking bench for dec3_8: combinational and registered builds side by side.
module tb_dec3_8;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic       we;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] combSel;
  logic       combWe;
  logic [7:0] combEn;
  logic [2:0] regSel;
  logic       regWe;
  logic [7:0] regEn;

  int checks = 0;
  int errors = 0;

  logic [7:0] expQ[$];
  vec_t       vecs[$];

  always #5 clk = ~clk;

  dec3_8 #(.REGISTERED(0)) dutComb (
    .clk           (clk),
    .rst_n         (rstN),
    .WriteRegister (combSel),
    .RegWrite      (combWe),
    .en            (combEn)
  );

  dec3_8 #(.REGISTERED(1)) dutReg (
    .clk           (clk),
    .rst_n         (rstN),
    .WriteRegister (regSel),
    .RegWrite      (regWe),
    .en            (regEn)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic popCheck(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      e = expQ.pop_front();
      check(name, act, e);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] one;

    // Stimulus table
    for (int i = 0; i < 8; i++) begin
      v.name = "comb_disabled"; v.sel = 3'(i); v.we = 1'b0; v.exp = 8'h00;
      vecs.push_back(v);
    end
    v.name = "comb_sel1"; v.sel = 3'b001; v.we = 1'b1; v.exp = 8'h02; vecs.push_back(v);
    v.name = "comb_sel5"; v.sel = 3'b101; v.we = 1'b1; v.exp = 8'h20; vecs.push_back(v);
    v.name = "comb_sel7"; v.sel = 3'b111; v.we = 1'b1; v.exp = 8'h80; vecs.push_back(v);
    for (int i = 0; i < 8; i++) begin
      one = 8'h01;
      v.name = "comb_sweep"; v.sel = 3'(i); v.we = 1'b1; v.exp = one << i;
      vecs.push_back(v);
    end
    v.name = "comb_sel7_hold"; v.sel = 3'b111; v.we = 1'b1; v.exp = 8'h80; vecs.push_back(v);
    v.name = "comb_we_drop";   v.sel = 3'b111; v.we = 1'b0; v.exp = 8'h00; vecs.push_back(v);

    // Registered instance held in reset with an active request
    rstN    = 1'b0;
    regSel  = 3'b101;
    regWe   = 1'b1;
    combSel = 3'b000;
    combWe  = 1'b0;
    #1;
    check("reg_reset_imm", regEn, 8'h00);

    // Combinational table
    foreach (vecs[n]) begin
      combSel = vecs[n].sel;
      combWe  = vecs[n].we;
      expQ.push_back(vecs[n].exp);
      #1;
      popCheck(vecs[n].name, combEn);
      if (vecs[n].we) check("comb_onehot", {7'b0, $onehot(combEn)}, 8'h01);
    end

    // Registered: release, latency, async clear
    @(negedge clk);
    rstN = 1'b1;
    expQ.push_back(8'h20);
    #1;
    check("reg_release_hold", regEn, 8'h00);
    @(posedge clk); #1;
    popCheck("reg_first_capture", regEn);

    @(negedge clk);
    regSel = 3'b010;
    expQ.push_back(8'h04);
    #1;
    check("reg_latency_old", regEn, 8'h20);
    @(posedge clk); #1;
    popCheck("reg_sel2", regEn);

    @(negedge clk);
    regSel = 3'b111;
    expQ.push_back(8'h80);
    @(posedge clk); #1;
    popCheck("reg_sel7", regEn);

    #2;
    rstN = 1'b0;
    #1;
    check("reg_async_clear", regEn, 8'h00);
    @(posedge clk); #1;
    check("reg_reset_held", regEn, 8'h00);

    @(negedge clk);
    rstN = 1'b1;
    expQ.push_back(8'h80);
    @(posedge clk); #1;
    popCheck("reg_recapture", regEn);

    @(negedge clk);
    regWe = 1'b0;
    expQ.push_back(8'h00);
    @(posedge clk); #1;
    popCheck("reg_we_drop", regEn);

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
